// File: rtl/mem_access_unit_if.sv
// Request, response and main_mem port signals of the load/store unit.
interface mem_access_unit_if;
    logic        i_req;
    logic        i_wr;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rd_data;
    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_val;
    logic [31:0] i_mem_val;

    // Execute stage and memory side
    modport master (
        output i_req, i_wr, i_funct3, i_addr, i_wr_data, i_mem_val,
        input  o_ready, o_done, o_err, o_rd_data, o_mem_addr, o_mem_wr_en, o_mem_wr_val
    );

    // Load/store unit side
    modport slave (
        input  i_req, i_wr, i_funct3, i_addr, i_wr_data, i_mem_val,
        output o_ready, o_done, o_err, o_rd_data, o_mem_addr, o_mem_wr_en, o_mem_wr_val
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, byte-addressed memory port with combinational
// read and synchronous write. Sub-word stores are done as read-modify-write.
module mem_access_unit #(
    parameter bit ERR_ON_MISALIGNED = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] wr_val_q, wr_val_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        misaligned;
    logic        req_bad;
    logic [31:0] merge_mask;

    // Classify the incoming request: unsupported funct3 or (optionally) misalignment
    always_comb begin
        misaligned = 1'b0;
        if (ERR_ON_MISALIGNED) begin
            case (bus.i_funct3[1:0])
                2'b01:   misaligned = bus.i_addr[0];
                2'b10:   misaligned = |bus.i_addr[1:0];
                default: misaligned = 1'b0;
            endcase
        end
        if (bus.i_wr) begin
            req_bad = bus.i_funct3[2] | (&bus.i_funct3[1:0]);
        end else begin
            req_bad = (&bus.i_funct3[1:0]) | (bus.i_funct3[2] & bus.i_funct3[1]);
        end
        req_bad = req_bad | misaligned;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_val_d  = wr_val_q;
        rd_data_d = rd_data_q;
        funct3_d  = funct3_q;
        wr_d      = wr_q;
        err_d     = err_q;
        // SH keeps the low halfword of store data, SB the low byte
        merge_mask = funct3_q[0] ? 32'h0000_ffff : 32'h0000_00ff;

        unique case (state_q)
            StIdle: begin
                if (bus.i_req) begin
                    addr_d    = bus.i_addr;
                    wr_data_d = bus.i_wr_data;
                    funct3_d  = bus.i_funct3;
                    wr_d      = bus.i_wr;
                    err_d     = req_bad;
                    if (req_bad) begin
                        state_d = StResp;
                    end else if (!bus.i_wr) begin
                        state_d = StLoad;
                    end else if (bus.i_funct3[1]) begin
                        wr_val_d = bus.i_wr_data;
                        state_d  = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                // Guard keeps rd_data untouched by anything but a load
                if (!wr_q) begin
                    case (funct3_q)
                        3'b000:  rd_data_d = {{24{bus.i_mem_val[7]}}, bus.i_mem_val[7:0]};
                        3'b100:  rd_data_d = {24'b0, bus.i_mem_val[7:0]};
                        3'b001:  rd_data_d = {{16{bus.i_mem_val[15]}}, bus.i_mem_val[15:0]};
                        3'b101:  rd_data_d = {16'b0, bus.i_mem_val[15:0]};
                        default: rd_data_d = bus.i_mem_val;
                    endcase
                end
                state_d = StResp;
            end
            StRmwRd: begin
                wr_val_d = (bus.i_mem_val & ~merge_mask) | (wr_data_q & merge_mask);
                state_d  = StWrite;
            end
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_val_q  <= '0;
            rd_data_q <= '0;
            funct3_q  <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_val_q  <= wr_val_d;
            rd_data_q <= rd_data_d;
            funct3_q  <= funct3_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_ready      = (state_q == StIdle);
    assign bus.o_done       = (state_q == StResp);
    assign bus.o_err        = (state_q == StResp) & err_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_mem_addr   = addr_q;
    // Reset on the write edge suppresses the write
    assign bus.o_mem_wr_en  = (state_q == StWrite) & ~i_rst;
    assign bus.o_mem_wr_val = wr_val_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed cases plus random requests against a byte-level memory model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit_if bus0 ();
    mem_access_unit_if bus1 ();

    mem_access_unit #(.ERR_ON_MISALIGNED(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    mem_access_unit #(.ERR_ON_MISALIGNED(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    logic [7:0]  mem     [4096];
    logic [7:0]  ref_mem [4096];
    logic [31:0] ref_rd  [2];
    int n_cmp = 0;
    int n_fail = 0;

    wire [11:0] a0 = bus0.o_mem_addr[11:0];
    wire [11:0] a1 = bus1.o_mem_addr[11:0];
    assign bus0.i_mem_val = {mem[a0 + 12'd3], mem[a0 + 12'd2], mem[a0 + 12'd1], mem[a0]};
    assign bus1.i_mem_val = {mem[a1 + 12'd3], mem[a1 + 12'd2], mem[a1 + 12'd1], mem[a1]};

    // Memory shared by both units; only one is active at a time
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
        end else begin
            if (bus0.o_mem_wr_en)
                for (int k = 0; k < 4; k++) mem[a0 + 12'(k)] <= bus0.o_mem_wr_val[8*k +: 8];
            if (bus1.o_mem_wr_en)
                for (int k = 0; k < 4; k++) mem[a1 + 12'(k)] <= bus1.o_mem_wr_val[8*k +: 8];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[a[11:0] + 12'(k)];
        return w;
    endfunction

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[a[11:0] + 12'(k)];
        return w;
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        int s = 4;
        if (f3 == 3'd0 || f3 == 3'd4) s = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) s = 2;
        return s;
    endfunction

    function automatic bit model_bad(input bit chk_align, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (wr && f3 > 3'd2) return 1'b1;
        if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (chk_align && (a % acc_size(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int v = 0;
        int n = acc_size(f3);
        for (int k = 0; k < n; k++) v += int'(ref_mem[a[11:0] + 12'(k)]) << (8 * k);
        // Signed loads: fold values at or above half-range into negatives
        if (f3 == 3'd0 && v >= 128) v -= 256;
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic drive(input bit sel, input bit req, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus0.i_req = req && !sel;
        bus1.i_req = req && sel;
        bus0.i_wr = wr;      bus1.i_wr = wr;
        bus0.i_funct3 = f3;  bus1.i_funct3 = f3;
        bus0.i_addr = a;     bus1.i_addr = a;
        bus0.i_wr_data = d;  bus1.i_wr_data = d;
    endtask

    // Issue one request at a negedge with ready high; returns at the negedge after done
    task automatic run_req(input bit sel, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        bit bad;
        int exp_done, exp_we, done_cyc, we_cnt, we_cyc, ready_low;
        logic [31:0] exp_wv, we_addr, we_val, obs_rd, obs_err;
        bad = model_bad(sel, wr, f3, a);
        exp_we = 0;
        exp_wv = '0;
        if (bad) exp_done = 1;
        else if (!wr) begin
            exp_done = 2;
            ref_rd[sel] = ref_load(f3, a);
        end else begin
            exp_done = (f3 == 3'd2) ? 2 : 3;
            exp_we = exp_done - 1;
            for (int k = 0; k < acc_size(f3); k++) ref_mem[a[11:0] + 12'(k)] = d[8*k +: 8];
            exp_wv = ref_word(a);
        end
        drive(sel, 1'b1, wr, f3, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        done_cyc = 0; we_cnt = 0; we_cyc = 0; ready_low = 0;
        we_addr = '0; we_val = '0; obs_rd = '0; obs_err = '0;
        for (int c = 1; c <= 6 && done_cyc == 0; c++) begin
            if (!(sel ? bus1.o_ready : bus0.o_ready)) ready_low++;
            if (sel ? bus1.o_mem_wr_en : bus0.o_mem_wr_en) begin
                we_cnt++;
                we_cyc = c;
                we_addr = sel ? bus1.o_mem_addr : bus0.o_mem_addr;
                we_val = sel ? bus1.o_mem_wr_val : bus0.o_mem_wr_val;
            end
            if (sel ? bus1.o_done : bus0.o_done) begin
                done_cyc = c;
                obs_err = {31'd0, sel ? bus1.o_err : bus0.o_err};
                obs_rd = sel ? bus1.o_rd_data : bus0.o_rd_data;
            end else begin
                @(negedge clk);
            end
        end
        check("done_cycle", done_cyc, exp_done);
        check("err_flag", obs_err, {31'd0, bad});
        check("ready_low_cycles", ready_low, exp_done);
        check("wr_en_count", we_cnt, (exp_we != 0) ? 1 : 0);
        if (exp_we != 0) begin
            check("wr_en_cycle", we_cyc, exp_we);
            check("wr_addr", we_addr, a);
            check("wr_val", we_val, exp_wv);
        end
        check("rd_data", obs_rd, ref_rd[sel]);
        @(negedge clk);
        check("ready_after", {31'd0, sel ? bus1.o_ready : bus0.o_ready}, 32'd1);
        check("mem_word", dut_word(a), ref_word(a));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        ref_mem[12'h100] = 8'h21; ref_mem[12'h101] = 8'h43;
        ref_mem[12'h102] = 8'h65; ref_mem[12'h103] = 8'h87;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        // Request held during reset must not be accepted
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_load = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("rst_ready", {31'd0, bus0.o_ready}, 32'd1);
        check("rst_done", {31'd0, bus0.o_done}, 32'd0);
        check("rst_err", {31'd0, bus0.o_err}, 32'd0);
        check("rst_wr_en", {31'd0, bus0.o_mem_wr_en}, 32'd0);
        check("rst_rd_data", bus0.o_rd_data, 32'd0);
        check("rst_mem_addr", bus0.o_mem_addr, 32'd0);
        check("rst_wr_val", bus0.o_mem_wr_val, 32'd0);
        check("rst_ready1", {31'd0, bus1.o_ready}, 32'd1);
        @(negedge clk);
        check("rst_no_accept", {31'd0, bus0.o_ready}, 32'd1);

        // Extension, loads back-to-back
        run_req(1'b0, 1'b0, 3'd0, 32'h103, 32'd0);
        check("lb_neg", bus0.o_rd_data, 32'hffff_ff87);
        run_req(1'b0, 1'b0, 3'd4, 32'h103, 32'd0);
        check("lbu", bus0.o_rd_data, 32'h0000_0087);
        run_req(1'b0, 1'b0, 3'd0, 32'h100, 32'd0);
        check("lb_pos", bus0.o_rd_data, 32'h0000_0021);
        run_req(1'b0, 1'b0, 3'd1, 32'h102, 32'd0);
        check("lh", bus0.o_rd_data, 32'hffff_8765);
        run_req(1'b0, 1'b0, 3'd5, 32'h102, 32'd0);
        check("lhu", bus0.o_rd_data, 32'h0000_8765);
        run_req(1'b0, 1'b0, 3'd2, 32'h100, 32'd0);
        check("lw", bus0.o_rd_data, 32'h8765_4321);

        // Sub-word and word stores
        run_req(1'b0, 1'b1, 3'd0, 32'h100, 32'haabb_ccdd);
        check("sb_keeps_rd", bus0.o_rd_data, 32'h8765_4321);
        run_req(1'b0, 1'b0, 3'd2, 32'h100, 32'd0);
        check("lw_after_sb", bus0.o_rd_data, 32'h8765_43dd);
        run_req(1'b0, 1'b1, 3'd1, 32'h100, 32'h1234_beef);
        check("sh_word", dut_word(32'h100), 32'h8765_beef);
        run_req(1'b0, 1'b1, 3'd2, 32'h200, 32'hdead_beef);
        check("sw_keeps_rd", bus0.o_rd_data, 32'h8765_43dd);
        run_req(1'b0, 1'b0, 3'd2, 32'h200, 32'd0);
        check("lw_after_sw", bus0.o_rd_data, 32'hdead_beef);

        // Errors
        run_req(1'b0, 1'b0, 3'd3, 32'h100, 32'd0);
        run_req(1'b0, 1'b1, 3'd4, 32'h100, 32'h5555_5555);
        check("err_keeps_rd", bus0.o_rd_data, 32'hdead_beef);
        run_req(1'b1, 1'b0, 3'd2, 32'h101, 32'd0);
        run_req(1'b1, 1'b0, 3'd1, 32'h102, 32'd0);
        check("lh_aligned_chk", bus1.o_rd_data, 32'hffff_8765);

        // Reset during the write cycle of an SB
        drive(1'b0, 1'b1, 1'b1, 3'd0, 32'h100, 32'h1122_3344);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rmw_write_cycle", {31'd0, bus0.o_mem_wr_en}, 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h200, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_mid_no_done", {31'd0, bus0.o_done}, 32'd0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        for (int c = 0; c < 2; c++) begin
            check("rst_mid_ready", {31'd0, bus0.o_ready}, 32'd1);
            check("rst_mid_done", {31'd0, bus0.o_done}, 32'd0);
            @(negedge clk);
        end
        check("rst_mid_mem", dut_word(32'h100), ref_word(32'h100));
        check("rst_mid_rd", bus0.o_rd_data, 32'd0);

        // Random traffic on both units
        for (int n = 0; n < 80; n++) begin
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)),
                    32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the execute stage and `main_mem`'s single 32-bit, byte-addressed, little-endian port. That port has a combinational read and a synchronous, word-wide write. This block handles RISC-V byte, halfword and word loads (with sign or zero extension) and stores. Byte and halfword stores use read-modify-write, because the memory port always writes 4 bytes.

## Interface
- `ERR_ON_MISALIGNED`, default 0. When 1, halfword accesses with addr[0]≠0 and word accesses with addr[1:0]≠0 are rejected with `o_err`. When 0, the address is passed through unchanged.
- `i_clk`  in  1  clock; single clock domain (type `clock`).
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  request valid. Accepted on a rising edge where `i_req & o_ready & !i_rst`.
- `i_wr`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `i_addr`  in  32  byte address (`data_val`).
- `i_wr_data`  in  32  store data; low byte/halfword used for SB/SH.
- `o_ready`  out  1  high only in IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  high with `o_done` when the request was rejected.
- `o_rd_data`  out  32  extended load result. Valid from the `o_done` cycle; held until the next load completes.
- `o_mem_addr`  out  32  address to `main_mem`.
- `o_mem_wr_en`  out  1  write enable to `main_mem`.
- `o_mem_wr_val`  out  32  write word to `main_mem`.
- `i_mem_val`  in  32  read word from `main_mem` at `o_mem_addr` (combinational).

## Operation
- **On accept**, these are latched into internal registers: addr, wr_data, funct3, wr.
- **`o_mem_addr`** is the latched addr register at all times (reset 0).
- **States:** IDLE, LOAD, RMW_RD, WRITE, RESP.
- **IDLE.** `o_ready`=1. On accept:
  - invalid request → RESP with error flag set;
  - load → LOAD;
  - SW → WRITE, with the write word = wr_data;
  - SB/SH → RMW_RD.
- **Invalid requests:**
  - load funct3 ∈ {011, 110, 111};
  - store funct3 ∉ {000, 001, 010};
  - misaligned access when `ERR_ON_MISALIGNED`=1.
- **LOAD.** Capture from `i_mem_val` into `o_rd_data`, then → RESP.
  - LB: {24{m[7]}, m[7:0]}.
  - LBU: {24'b0, m[7:0]}.
  - LH: {16{m[15]}, m[15:0]}.
  - LHU: {16'b0, m[15:0]}.
  - LW: m.
- **RMW_RD.** Capture the merged word into the write-word register, then → WRITE.
  - SB: {m[31:8], wr_data[7:0]}.
  - SH: {m[31:16], wr_data[15:0]}.
- **WRITE.**
  - `o_mem_wr_en` = !`i_rst`; `o_mem_wr_val` = write-word register.
  - Then → RESP.
- **RESP.** `o_done`=1, `o_err` = error flag; → IDLE.
- **`o_mem_wr_val` outside WRITE** holds its last value (reset 0).
- **`o_mem_wr_en` outside WRITE** is 0.
- **Stores and errors** never modify `o_rd_data`.
- **Errors** never assert `o_mem_wr_en`.
- **Unaligned SB/SH with `ERR_ON_MISALIGNED`=0** rewrite bytes addr+1..addr+3 with their just-read values. This is a required, benign side effect.
- **Reset mid-operation.** On any edge with `i_rst`=1:
  - the FSM returns to IDLE and the flags clear;
  - no memory write occurs on that edge (enable is gated by `!i_rst`);
  - an in-flight request is dropped without `o_done`.

## Timing
- Cycle 0 is the accept edge's cycle. Completion (`o_done`) cycle by request type:
  - error: cycle 1;
  - load: cycle 2;
  - SW: cycle 2, with `o_mem_wr_en` in cycle 1;
  - SB/SH: cycle 3, with `o_mem_wr_en` in cycle 2.
- `o_mem_wr_en` is high for exactly one cycle per store.
- `o_ready`=0 from cycle 1 through the `o_done` cycle, and 1 the cycle after.
- Back-to-back operation: the next request can be accepted in the first cycle `o_ready`=1.
- `i_req` while not ready is ignored and not queued.
- After reset, the state is IDLE and the outputs are:
  - `o_ready`=1;
  - `o_done`, `o_err`, `o_mem_wr_en` = 0;
  - `o_rd_data`, `o_mem_addr`, `o_mem_wr_val` = 0.
- Requests presented while `i_rst`=1 are ignored.

## Test plan
- **Sign and zero extension.** Memory 0x100..0x103 = 21 43 65 87.
  - LB 0x103 → `o_rd_data`=0xFFFFFF87.
  - LBU 0x103 → 0x00000087.
  - LB 0x100 → 0x00000021.
  - Each with `o_done` in cycle 2.
- **Halfword and word loads**, same memory.
  - LH 0x102 → 0xFFFF8765; LHU 0x102 → 0x00008765.
  - LW 0x100 → 0x87654321.
  - Back-to-back issue: `o_ready` low for exactly 2 cycles per load.
- **Sub-word stores.**
  - SB 0x100 with data 0xAABBCCDD: `o_mem_wr_en` only in cycle 2, `o_mem_wr_val`=0x876543DD, `o_done` cycle 3. A following LW 0x100 → 0x876543DD.
  - SH 0x100 with data 0x1234BEEF → word 0x8765BEEF.
- **Word store.** SW 0x200 with data 0xDEADBEEF: `o_mem_wr_en` in cycle 1 with `o_mem_addr`=0x200, `o_done` cycle 2. LW 0x200 → 0xDEADBEEF; `o_rd_data` unchanged between.
- **Error cases.**
  - Load funct3=011 and store funct3=100: `o_done`=`o_err`=1 in cycle 1, no `o_mem_wr_en`, `o_rd_data` unchanged.
  - With `ERR_ON_MISALIGNED`=1, LW 0x101 → error; LH 0x102 succeeds.
- **Reset and ignored requests.**
  - Assert `i_rst` in the WRITE cycle of SB 0x100: memory unchanged, no `o_done`, `o_ready`=1 after release.
  - `i_req` held during reset is not accepted.
